// File: rtl/huff_feeder_pkg.sv
// Shared constants, state encoding and table-entry helpers for the Huffman feeder.
package huff_feeder_pkg;

    localparam int HUFF_CODE_W  = 8;
    localparam int HUFF_LEN_W   = 4;
    localparam int HUFF_WORD_W  = 32;
    localparam int HUFF_MAX_LEN = 8;
    localparam int HUFF_ACC_W   = 6;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_PAD   = 2'd2;
    localparam logic [1:0] ST_PUSH  = 2'd3;

    typedef enum logic [1:0] {
        S_RUN   = ST_RUN,
        S_DRAIN = ST_DRAIN,
        S_PAD   = ST_PAD,
        S_PUSH  = ST_PUSH
    } huff_state_e;

    typedef struct packed {
        logic [HUFF_CODE_W-1:0] code;
        logic [HUFF_LEN_W-1:0]  len;
    } tbl_entry_t;

    function automatic logic len_ok(input logic [HUFF_LEN_W-1:0] len);
        return (len != '0) && (len <= HUFF_LEN_W'(HUFF_MAX_LEN));
    endfunction

    function automatic logic [HUFF_CODE_W-1:0] code_mask(input logic [HUFF_LEN_W-1:0] len);
        logic [HUFF_CODE_W:0] m;
        m = (HUFF_CODE_W+1)'(1) << len;
        m = m - (HUFF_CODE_W+1)'(1);
        return (len >= HUFF_LEN_W'(HUFF_MAX_LEN)) ? '1 : m[HUFF_CODE_W-1:0];
    endfunction

    // Padding chunk that brings acc toward the word boundary without overshooting it.
    function automatic logic [HUFF_LEN_W-1:0] pad_len(input logic [HUFF_ACC_W-1:0] acc);
        logic [HUFF_ACC_W-1:0] room;
        room = HUFF_ACC_W'(HUFF_WORD_W) - acc;
        return (room >= HUFF_ACC_W'(HUFF_MAX_LEN)) ? HUFF_LEN_W'(HUFF_MAX_LEN) : room[HUFF_LEN_W-1:0];
    endfunction

endpackage

// File: rtl/huff_feeder_sym_fifo.sv
// Synchronous symbol FIFO; pop on empty is ignored, push on full succeeds only alongside a pop.
module huff_sym_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage arrays carry no reset; the pointers alone define what is valid.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/huff_feeder.sv
// Symbol-to-code feeder: FIFO, 256-entry code table, output stage and optional flush FSM.
// Define HUFF_FEEDER_FLUSH_EN to enable end-of-stream padding (DRAIN/PAD/PUSH).
module huff_feeder
    import huff_feeder_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [7:0]             s_symbol,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic                   tbl_we,
    input  logic [7:0]             tbl_addr,
    input  logic [HUFF_CODE_W-1:0] tbl_code,
    input  logic [HUFF_LEN_W-1:0]  tbl_len,
    input  logic                   flush_req,
    output logic [HUFF_CODE_W-1:0] code,
    output logic [HUFF_LEN_W-1:0]  length,
    output logic                   ce,
    output logic                   flush_done,
    output logic                   err
);

    logic [7:0]             fifo_dout;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;
    logic [7:0]             addr_q;
    logic                   v1;
    logic                   v2;
    tbl_entry_t             tbl [256];
    tbl_entry_t             entry_q;
    logic                   hit_ok;
    logic                   hit_bad;
    logic [HUFF_CODE_W-1:0] hit_code;
    logic                   emit;
    logic [HUFF_CODE_W-1:0] emit_code;
    logic [HUFF_LEN_W-1:0]  emit_len;

    assign push = s_valid && s_ready;
    assign pop  = !fifo_empty;

    huff_sym_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clock  (clock),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .din    (s_symbol),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            addr_q <= '0;
        end else begin
            v1 <= pop;
            v2 <= v1;
            if (pop) addr_q <= fifo_dout;
        end
    end

    // Table survives reset; a same-address write and read returns the old entry.
    always_ff @(posedge clock) begin
        if (tbl_we) tbl[tbl_addr] <= '{code: tbl_code, len: tbl_len};
        entry_q <= tbl[addr_q];
    end

    assign hit_ok   = v2 && len_ok(entry_q.len);
    assign hit_bad  = v2 && !len_ok(entry_q.len);
    assign hit_code = entry_q.code & code_mask(entry_q.len);

`ifdef HUFF_FEEDER_FLUSH_EN
    huff_state_e            state;
    huff_state_e            state_next;
    logic [HUFF_ACC_W-1:0]  acc;
    logic [HUFF_LEN_W-1:0]  pad;
    logic                   drained;
    logic                   done;

    assign s_ready = resetn && !fifo_full && (state == S_RUN);
    assign drained = fifo_empty && !v1 && !v2;
    assign pad     = pad_len(acc);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path infers a latch.
        state_next = state;
        emit       = 1'b0;
        emit_code  = '0;
        emit_len   = '0;
        done       = 1'b0;
        unique case (state)
            S_RUN: begin
                emit      = hit_ok;
                emit_code = hit_code;
                emit_len  = entry_q.len;
                if (flush_req) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                emit      = hit_ok;
                emit_code = hit_code;
                emit_len  = entry_q.len;
                if (drained) begin
                    if (acc == '0) begin
                        state_next = S_RUN;
                        done       = 1'b1;
                    end else if (acc >= HUFF_ACC_W'(HUFF_WORD_W)) begin
                        state_next = S_PUSH;
                    end else begin
                        state_next = S_PAD;
                    end
                end
            end
            S_PAD: begin
                emit     = 1'b1;
                emit_len = pad;
                if (acc + {2'b00, pad} == HUFF_ACC_W'(HUFF_WORD_W)) state_next = S_PUSH;
            end
            S_PUSH: begin
                emit       = 1'b1;
                done       = 1'b1;
                state_next = S_RUN;
            end
        endcase
    end

    // acc mirrors the downstream coder's bit position within its 32-bit word.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state      <= S_RUN;
            acc        <= '0;
            flush_done <= 1'b0;
        end else begin
            state      <= state_next;
            flush_done <= done;
            if (state == S_PUSH) begin
                acc <= '0;
            end else if (emit) begin
                if (acc >= HUFF_ACC_W'(HUFF_WORD_W))
                    acc <= acc + {2'b00, emit_len} - HUFF_ACC_W'(HUFF_WORD_W);
                else
                    acc <= acc + {2'b00, emit_len};
            end
        end
    end
`else
    logic unused_flush_req;

    assign unused_flush_req = flush_req;
    assign s_ready          = resetn && !fifo_full;
    assign emit             = hit_ok;
    assign emit_code        = hit_code;
    assign emit_len         = entry_q.len;
    assign flush_done       = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!resetn) begin
            ce     <= 1'b0;
            code   <= '0;
            length <= '0;
            err    <= 1'b0;
        end else begin
            ce <= emit;
            if (emit) begin
                code   <= emit_code;
                length <= emit_len;
            end
            if (hit_bad) err <= 1'b1;
        end
    end

endmodule
